// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared types and constants for the writeback arbiter
// Contents: thread/register/lane types, wb_result_t payload, scalar mask helper.
package writeback_arbiter_pkg;

   localparam int THREADS_PER_CORE   = 4;
   localparam int DEFAULT_FIFO_DEPTH = 2;
   localparam int NUM_VECTOR_LANES   = 16;

   typedef logic [$clog2(THREADS_PER_CORE)-1:0] local_thread_idx_t;
   typedef logic [4:0]                          register_idx_t;
   typedef logic [NUM_VECTOR_LANES-1:0]         vector_lane_mask_t;
   typedef logic [NUM_VECTOR_LANES-1:0][31:0]   vector_t;

   // dest_reg carries the destination register ("reg" is a keyword).
   typedef struct packed {
      local_thread_idx_t thread_idx;
      logic              is_vector;
      register_idx_t     dest_reg;
      vector_lane_mask_t mask;
      vector_t           value;
   } wb_result_t;

   // Scalar writes always enable every lane; the register file only reads lane 0.
   function automatic wb_result_t force_scalar_mask(input wb_result_t r);
      wb_result_t o;
      o = r;
      if (!o.is_vector)
         o.mask = '1;
      return o;
   endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - producer/consumer bundle for the writeback arbiter
// slave modport (arbiter): int/fp valid+result in, ready out; mem valid/result/rollback in;
// wb_writeback_* and wb_rollback_* out. master modport is the mirror view.
interface writeback_arbiter_if;
   import writeback_arbiter_pkg::*;

   logic              int_valid;
   logic              int_ready;
   wb_result_t        int_result;
   logic              fp_valid;
   logic              fp_ready;
   wb_result_t        fp_result;
   logic              mem_valid;
   wb_result_t        mem_result;
   logic              mem_rollback_en;
   local_thread_idx_t mem_rollback_thread_idx;
   logic              wb_writeback_en;
   local_thread_idx_t wb_writeback_thread_idx;
   logic              wb_writeback_is_vector;
   register_idx_t     wb_writeback_reg;
   vector_t           wb_writeback_value;
   vector_lane_mask_t wb_writeback_mask;
   logic              wb_rollback_en;
   local_thread_idx_t wb_rollback_thread_idx;

   modport slave (
      input  int_valid, int_result, fp_valid, fp_result,
             mem_valid, mem_result, mem_rollback_en, mem_rollback_thread_idx,
      output int_ready, fp_ready,
             wb_writeback_en, wb_writeback_thread_idx, wb_writeback_is_vector,
             wb_writeback_reg, wb_writeback_value, wb_writeback_mask,
             wb_rollback_en, wb_rollback_thread_idx
   );

   modport master (
      output int_valid, int_result, fp_valid, fp_result,
             mem_valid, mem_result, mem_rollback_en, mem_rollback_thread_idx,
      input  int_ready, fp_ready,
             wb_writeback_en, wb_writeback_thread_idx, wb_writeback_is_vector,
             wb_writeback_reg, wb_writeback_value, wb_writeback_mask,
             wb_rollback_en, wb_rollback_thread_idx
   );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// rtl/writeback_arbiter_fifo.sv - result queue with per-entry valid and thread flush
// Ports: clk, reset_n; push_en/push_data (ignored when full); pop_en (consume valid head);
// flush_en/flush_thread_idx (invalidate matching entries); head/head_valid/full.
module wb_result_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push_en,
   input  wb_result_t        push_data,
   input  logic              pop_en,
   input  logic              flush_en,
   input  local_thread_idx_t flush_thread_idx,
   output wb_result_t        head,
   output logic              head_valid,
   output logic              full
);
   localparam int PW = $clog2(DEPTH);

   wb_result_t       data [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW:0]      count;
   logic             not_empty;
   logic             do_push;
   logic             do_pop;

   assign not_empty  = (count != '0);
   assign full       = (count == (PW+1)'(DEPTH));
   assign head       = data[rd_ptr];
   assign head_valid = not_empty && valid[rd_ptr];
   assign do_push    = push_en && !full;
   // Squashed heads drain on their own so the arbiter only ever sees live results.
   assign do_pop     = not_empty && (pop_en || !valid[rd_ptr]);

   always_ff @(posedge clk) begin
      if (do_push)
         data[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (flush_en && data[i].thread_idx == flush_thread_idx)
               valid[i] <= 1'b0;
         end
         // A result arriving in the rollback cycle for the same thread is taken but dead.
         if (do_push) begin
            valid[wr_ptr] <= !(flush_en && push_data.thread_idx == flush_thread_idx);
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges int/fp/mem results into one register write per cycle
// Ports: clk, reset_n (sync, active low); bus (writeback_arbiter_if.slave): int/fp queued
// inputs with ready, mem input (never stalled) with rollback request, registered
// wb_writeback_* write port and wb_rollback_* broadcast.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input logic              clk,
   input logic              reset_n,
   writeback_arbiter_if.slave bus
);
   wb_result_t        int_head;
   wb_result_t        fp_head;
   logic              int_head_valid;
   logic              fp_head_valid;
   logic              int_full;
   logic              fp_full;
   logic              grant_int;
   logic              grant_fp;
   logic              sel_valid;
   wb_result_t        sel_result;
   logic              squash;
   logic              rr_fp;
   logic              wb_en_q;
   wb_result_t        wb_q;
   logic              rb_en_q;
   local_thread_idx_t rb_thread_q;

   wb_result_fifo #(.DEPTH(FIFO_DEPTH)) int_fifo (
      .clk              (clk),
      .reset_n          (reset_n),
      .push_en          (bus.int_valid),
      .push_data        (bus.int_result),
      .pop_en           (grant_int),
      .flush_en         (bus.mem_rollback_en),
      .flush_thread_idx (bus.mem_rollback_thread_idx),
      .head             (int_head),
      .head_valid       (int_head_valid),
      .full             (int_full)
   );

   wb_result_fifo #(.DEPTH(FIFO_DEPTH)) fp_fifo (
      .clk              (clk),
      .reset_n          (reset_n),
      .push_en          (bus.fp_valid),
      .push_data        (bus.fp_result),
      .pop_en           (grant_fp),
      .flush_en         (bus.mem_rollback_en),
      .flush_thread_idx (bus.mem_rollback_thread_idx),
      .head             (fp_head),
      .head_valid       (fp_head_valid),
      .full             (fp_full)
   );

   assign bus.int_ready = !int_full;
   assign bus.fp_ready  = !fp_full;

   // mem wins outright; otherwise rr_fp breaks the tie between two live heads.
   always_comb begin
      grant_int  = 1'b0;
      grant_fp   = 1'b0;
      sel_valid  = 1'b0;
      sel_result = bus.mem_result;
      if (bus.mem_valid) begin
         sel_valid = 1'b1;
      end else if (int_head_valid && (!fp_head_valid || !rr_fp)) begin
         grant_int  = 1'b1;
         sel_valid  = 1'b1;
         sel_result = int_head;
      end else if (fp_head_valid) begin
         grant_fp   = 1'b1;
         sel_valid  = 1'b1;
         sel_result = fp_head;
      end
   end

   // The granted result is still consumed when squashed; it simply never writes.
   assign squash = bus.mem_rollback_en && (sel_result.thread_idx == bus.mem_rollback_thread_idx);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wb_en_q     <= 1'b0;
         wb_q        <= '0;
         rb_en_q     <= 1'b0;
         rb_thread_q <= '0;
         rr_fp       <= 1'b0;
      end else begin
         wb_en_q <= sel_valid && !squash;
         if (sel_valid && !squash)
            wb_q <= force_scalar_mask(sel_result);
         rb_en_q     <= bus.mem_rollback_en;
         rb_thread_q <= bus.mem_rollback_thread_idx;
         if (!bus.mem_valid && int_head_valid && fp_head_valid)
            rr_fp <= !rr_fp;
      end
   end

   assign bus.wb_writeback_en         = wb_en_q;
   assign bus.wb_writeback_thread_idx = wb_q.thread_idx;
   assign bus.wb_writeback_is_vector  = wb_q.is_vector;
   assign bus.wb_writeback_reg        = wb_q.dest_reg;
   assign bus.wb_writeback_value      = wb_q.value;
   assign bus.wb_writeback_mask       = wb_q.mask;
   assign bus.wb_rollback_en          = rb_en_q;
   assign bus.wb_rollback_thread_idx  = rb_thread_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
   import writeback_arbiter_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   writeback_arbiter_if wbi ();

   writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (wbi)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      wb_result_t r;
      bit         v;
   } ent_t;
   ent_t iq[$];
   ent_t fq[$];
   bit rr_fp = 1'b0;

   bit                exp_en = 1'b0;
   bit                exp_zero = 1'b1;
   bit                exp_rb = 1'b0;
   wb_result_t        exp_res = '0;
   local_thread_idx_t exp_rbt = '0;
   bit                chk_on = 1'b0;

   typedef struct {
      int                cyc;
      local_thread_idx_t thr;
      register_idx_t     rg;
      vector_lane_mask_t mask;
      logic [31:0]       lane0;
   } wlog_t;
   wlog_t             wlog[$];
   local_thread_idx_t rblog[$];

   task automatic chk(input string nm, input logic [599:0] act, input logic [599:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic wb_result_t mk(input int thr, input int rg, input int vec);
      wb_result_t r;
      r.thread_idx = local_thread_idx_t'(thr);
      r.is_vector  = (vec != 0);
      r.dest_reg   = register_idx_t'(rg);
      r.mask       = vector_lane_mask_t'($urandom);
      for (int i = 0; i < NUM_VECTOR_LANES; i++)
         r.value[i] = $urandom;
      return r;
   endfunction

   // Reference behaviour from the arbitration rules, applied to the inputs seen at this edge.
   task automatic model_step();
      wb_result_t        res;
      bit                ih, fh, ir, fr, rb, pi, pf, take;
      local_thread_idx_t t;
      if (!reset_n) begin
         iq.delete();
         fq.delete();
         rr_fp    = 1'b0;
         exp_en   = 1'b0;
         exp_res  = '0;
         exp_rb   = 1'b0;
         exp_rbt  = '0;
         exp_zero = 1'b1;
         return;
      end
      exp_zero = 1'b0;
      rb   = wbi.mem_rollback_en;
      t    = wbi.mem_rollback_thread_idx;
      ir   = iq.size() < DEPTH;
      fr   = fq.size() < DEPTH;
      ih   = (iq.size() > 0) && iq[0].v;
      fh   = (fq.size() > 0) && fq[0].v;
      pi   = 1'b0;
      pf   = 1'b0;
      take = 1'b0;
      res  = '0;
      if (wbi.mem_valid) begin
         take = 1'b1;
         res  = wbi.mem_result;
      end else if (ih && fh) begin
         take = 1'b1;
         if (rr_fp) begin res = fq[0].r; pf = 1'b1; end
         else       begin res = iq[0].r; pi = 1'b1; end
         rr_fp = !rr_fp;
      end else if (ih) begin
         take = 1'b1; res = iq[0].r; pi = 1'b1;
      end else if (fh) begin
         take = 1'b1; res = fq[0].r; pf = 1'b1;
      end
      exp_en = take && !(rb && res.thread_idx == t);
      if (exp_en) begin
         exp_res = res;
         if (!res.is_vector) exp_res.mask = '1;
      end
      if (pi || (iq.size() > 0 && !iq[0].v)) void'(iq.pop_front());
      if (pf || (fq.size() > 0 && !fq[0].v)) void'(fq.pop_front());
      if (rb) begin
         foreach (iq[k]) if (iq[k].r.thread_idx == t) iq[k].v = 1'b0;
         foreach (fq[k]) if (fq[k].r.thread_idx == t) fq[k].v = 1'b0;
      end
      if (wbi.int_valid && ir)
         iq.push_back('{r: wbi.int_result, v: !(rb && wbi.int_result.thread_idx == t)});
      if (wbi.fp_valid && fr)
         fq.push_back('{r: wbi.fp_result, v: !(rb && wbi.fp_result.thread_idx == t)});
      exp_rb  = rb;
      exp_rbt = t;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      model_step();
      cyc++;
      chk_on = 1'b1;
   endtask

   task automatic drive_idle();
      wbi.int_valid = 1'b0;
      wbi.int_result = '0;
      wbi.fp_valid = 1'b0;
      wbi.fp_result = '0;
      wbi.mem_valid = 1'b0;
      wbi.mem_result = '0;
      wbi.mem_rollback_en = 1'b0;
      wbi.mem_rollback_thread_idx = '0;
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("wb_en", 600'(wbi.wb_writeback_en), 600'(exp_en));
         chk("rb_en", 600'(wbi.wb_rollback_en), 600'(exp_rb));
         chk("int_ready", 600'(wbi.int_ready), 600'(iq.size() < DEPTH));
         chk("fp_ready", 600'(wbi.fp_ready), 600'(fq.size() < DEPTH));
         if (exp_en || exp_zero) begin
            chk("wb_thread", 600'(wbi.wb_writeback_thread_idx), 600'(exp_res.thread_idx));
            chk("wb_is_vector", 600'(wbi.wb_writeback_is_vector), 600'(exp_res.is_vector));
            chk("wb_reg", 600'(wbi.wb_writeback_reg), 600'(exp_res.dest_reg));
            chk("wb_mask", 600'(wbi.wb_writeback_mask), 600'(exp_res.mask));
            chk("wb_value", 600'(wbi.wb_writeback_value), 600'(exp_res.value));
         end
         if (exp_rb)
            chk("rb_thread", 600'(wbi.wb_rollback_thread_idx), 600'(exp_rbt));
         if (wbi.wb_writeback_en)
            wlog.push_back('{cyc: cyc, thr: wbi.wb_writeback_thread_idx, rg: wbi.wb_writeback_reg,
                             mask: wbi.wb_writeback_mask, lane0: wbi.wb_writeback_value[0]});
         if (wbi.wb_rollback_en)
            rblog.push_back(wbi.wb_rollback_thread_idx);
      end
   end

   initial begin
      wb_result_t r;
      int  ic, fc;
      bit  acc_i, acc_f, saw_full;

      drive_idle();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
      chk("rst_int_ready", 600'(wbi.int_ready), 600'(1));
      chk("rst_fp_ready", 600'(wbi.fp_ready), 600'(1));
      chk("rst_wb_en", 600'(wbi.wb_writeback_en), 600'(0));

      // mem beats a pending int head; int follows one cycle later
      wlog.delete();
      wbi.int_valid = 1'b1; wbi.int_result = mk(0, 5, 0);
      step();
      wbi.int_valid = 1'b0;
      wbi.mem_valid = 1'b1; wbi.mem_result = mk(1, 7, 1);
      step();
      wbi.mem_valid = 1'b0;
      repeat (3) step();
      chk("s1_count", 600'(wlog.size()), 600'(2));
      if (wlog.size() == 2) begin
         chk("s1_first_reg", 600'(wlog[0].rg), 600'(7));
         chk("s1_second_reg", 600'(wlog[1].rg), 600'(5));
         chk("s1_gap", 600'(wlog[1].cyc - wlog[0].cyc), 600'(1));
      end

      // int and fp offered every cycle: grants alternate, queues fill
      wlog.delete();
      ic = 0; fc = 16; saw_full = 1'b0;
      for (int k = 0; k < 10; k++) begin
         wbi.int_valid = 1'b1; wbi.int_result = mk(k % 4, ic, 0);
         wbi.fp_valid  = 1'b1; wbi.fp_result  = mk(k % 4, fc, 1);
         acc_i = wbi.int_ready;
         acc_f = wbi.fp_ready;
         if (!acc_i || !acc_f) saw_full = 1'b1;
         step();
         if (acc_i) ic++;
         if (acc_f) fc++;
      end
      drive_idle();
      repeat (8) step();
      chk("s2_saw_not_ready", 600'(saw_full), 600'(1));
      chk("s2_count", 600'(wlog.size() >= 6), 600'(1));
      for (int k = 0; k < 6 && k < wlog.size(); k++)
         chk("s2_alternate", 600'(wlog[k].rg >= 16), 600'(k % 2));

      // rollback of T1 kills queued r3, keeps T2 r4
      wlog.delete(); rblog.delete();
      wbi.mem_valid = 1'b1; wbi.mem_result = mk(3, 20, 0);
      wbi.int_valid = 1'b1; wbi.int_result = mk(1, 3, 0);
      step();
      wbi.mem_result = mk(3, 21, 0);
      wbi.int_result = mk(2, 4, 0);
      step();
      drive_idle();
      wbi.mem_rollback_en = 1'b1; wbi.mem_rollback_thread_idx = 2'd1;
      step();
      drive_idle();
      repeat (4) step();
      chk("s3_count", 600'(wlog.size()), 600'(3));
      if (wlog.size() == 3) begin
         chk("s3_reg2", 600'(wlog[2].rg), 600'(4));
         chk("s3_thr2", 600'(wlog[2].thr), 600'(2));
      end
      chk("s3_rb_count", 600'(rblog.size()), 600'(1));
      if (rblog.size() == 1) chk("s3_rb_thr", 600'(rblog[0]), 600'(1));

      // faulting mem write of the rolled-back thread is dropped, other thread writes
      wlog.delete(); rblog.delete();
      wbi.mem_valid = 1'b1; wbi.mem_result = mk(0, 9, 0);
      wbi.mem_rollback_en = 1'b1; wbi.mem_rollback_thread_idx = 2'd0;
      step();
      wbi.mem_result = mk(3, 10, 0);
      step();
      drive_idle();
      repeat (3) step();
      chk("s4_count", 600'(wlog.size()), 600'(1));
      if (wlog.size() == 1) begin
         chk("s4_thr", 600'(wlog[0].thr), 600'(3));
         chk("s4_reg", 600'(wlog[0].rg), 600'(10));
      end
      chk("s4_rb_count", 600'(rblog.size()), 600'(2));

      // scalar write forces mask to all ones
      wlog.delete();
      r = mk(2, 11, 0);
      r.value[0] = 32'h1234;
      r.mask = 16'h0;
      wbi.int_valid = 1'b1; wbi.int_result = r;
      step();
      drive_idle();
      repeat (3) step();
      chk("s5_count", 600'(wlog.size()), 600'(1));
      if (wlog.size() == 1) begin
         chk("s5_mask", 600'(wlog[0].mask), 600'(16'hFFFF));
         chk("s5_lane0", 600'(wlog[0].lane0), 600'(32'h1234));
      end

      // fill both queues behind mem traffic, then reset drops everything
      for (int k = 0; k < 3; k++) begin
         wbi.mem_valid = 1'b1; wbi.mem_result = mk(3, k, 0);
         wbi.int_valid = 1'b1; wbi.int_result = mk(1, 12 + k, 0);
         wbi.fp_valid  = 1'b1; wbi.fp_result  = mk(2, 24 + k, 1);
         step();
      end
      chk("s6_int_full", 600'(wbi.int_ready), 600'(0));
      drive_idle();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      wlog.delete();
      repeat (5) step();
      chk("s6_no_writes", 600'(wlog.size()), 600'(0));
      chk("s6_int_ready", 600'(wbi.int_ready), 600'(1));
      chk("s6_fp_ready", 600'(wbi.fp_ready), 600'(1));

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         reset_n = ($urandom_range(0, 199) != 0);
         wbi.int_valid = ($urandom_range(0, 99) < 60);
         wbi.int_result = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 1)));
         wbi.fp_valid = ($urandom_range(0, 99) < 60);
         wbi.fp_result = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 1)));
         wbi.mem_valid = ($urandom_range(0, 99) < 30);
         wbi.mem_result = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 1)));
         wbi.mem_rollback_en = ($urandom_range(0, 99) < 15);
         wbi.mem_rollback_thread_idx = local_thread_idx_t'($urandom_range(0, 3));
         step();
      end
      reset_n = 1'b1;
      drive_idle();
      repeat (6) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
